// File: rtl/warp_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | warp_sched_pkg : shared types and helpers for the warp scheduler      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package warp_sched_pkg;

  localparam int MAX_WARPS = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH      = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_e;

  // Index width for n warps; a single-bit index is the floor.
  function automatic int warp_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_WARPS-1:0] onehot(input logic [31:0] idx);
    return {{(MAX_WARPS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/warp_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | warp_scheduler_if : warp-state, push-control and issue handshake bus  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface warp_scheduler_if #(
  parameter int NUM_WARPS = 4
);
  import warp_sched_pkg::*;

  localparam int WARP_W = warp_w(NUM_WARPS);

  logic [NUM_WARPS-1:0] ready_warps;
  logic                 push_en;
  logic [WARP_W-1:0]    push_start;
  logic [WARP_W:0]      push_count;
  logic                 matmul_done;
  logic                 push_valid;
  logic [WARP_W-1:0]    push_warp;
  logic                 pause;
  logic                 push_active;
  logic                 issue_valid;
  logic [WARP_W-1:0]    issue_warp;
  logic                 issue_ready;
  logic                 all_busy;

  // Master: the surrounding control/state logic. Slave: the scheduler.
  modport master (
    output ready_warps, push_en, push_start, push_count, matmul_done, issue_ready,
    input  push_valid, push_warp, pause, push_active, issue_valid, issue_warp, all_busy
  );

  modport slave (
    input  ready_warps, push_en, push_start, push_count, matmul_done, issue_ready,
    output push_valid, push_warp, pause, push_active, issue_valid, issue_warp, all_busy
  );

endinterface
`default_nettype wire

// File: rtl/warp_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin pick over N requests, owns the scan pointer  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N-1:0]                req,
  input  logic                        advance,
  output logic                        grant_valid,
  output logic [warp_sched_pkg::warp_w(N)-1:0] grant_idx
);
  import warp_sched_pkg::*;

  localparam int W = warp_w(N);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;
  logic [W-1:0] cand;

  // Scan from the far end back toward ptr so the nearest request wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_q + W'(k);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = grant_idx + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | warp_scheduler : push-window sequencer plus round-robin issue pick    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module warp_scheduler #(
  parameter int NUM_WARPS = 4
) (
  input  logic            clk,
  input  logic            reset,
  warp_scheduler_if.slave bus
);
  import warp_sched_pkg::*;

  localparam int WARP_W = warp_w(NUM_WARPS);

  sched_state_e         state_q;
  sched_state_e         state_d;
  logic [WARP_W-1:0]    start_q;
  logic [WARP_W-1:0]    start_d;
  logic [WARP_W:0]      count_q;
  logic [WARP_W:0]      count_d;
  logic [WARP_W-1:0]    step_q;
  logic [WARP_W-1:0]    step_d;

  logic [WARP_W-1:0]    cur;
  logic                 cur_ready;
  logic                 last_step;
  logic                 push_valid;
  logic [WARP_W-1:0]    push_warp;
  logic                 pause;
  logic                 push_active;
  logic [NUM_WARPS-1:0] push_mask;
  logic [NUM_WARPS-1:0] eligible;
  logic                 issue_valid;
  logic [WARP_W-1:0]    issue_warp;

  // Window position wraps naturally in WARP_W bits.
  assign cur       = start_q + step_q;
  assign cur_ready = bus.ready_warps[cur];
  assign last_step = ({1'b0, step_q} == (count_q - (WARP_W + 1)'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= '0;
      count_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    count_d = count_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (bus.push_en) begin
          start_d = bus.push_start;
          count_d = (bus.push_count == '0) ? (WARP_W + 1)'(NUM_WARPS) : bus.push_count;
          step_d  = '0;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (bus.matmul_done) begin
          state_d = IDLE;
        end else if (cur_ready) begin
          if (last_step) begin
            state_d = WAIT_DONE;
          end else begin
            step_d = step_q + WARP_W'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (bus.matmul_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A grant is presented even in the cycle matmul_done aborts the window.
  always_comb begin
    push_valid  = 1'b0;
    push_warp   = '0;
    pause       = 1'b0;
    push_active = (state_q != IDLE);
    if (state_q == PUSH) begin
      if (cur_ready) begin
        push_valid = 1'b1;
        push_warp  = cur;
      end else begin
        pause = 1'b1;
      end
    end
  end

  assign push_mask = push_valid ? NUM_WARPS'(onehot(32'(push_warp))) : '0;
  assign eligible  = bus.ready_warps & ~push_mask;

  rr_arbiter #(
    .N (NUM_WARPS)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req         (eligible),
    .advance     (bus.issue_ready),
    .grant_valid (issue_valid),
    .grant_idx   (issue_warp)
  );

  assign bus.push_valid  = push_valid;
  assign bus.push_warp   = push_warp;
  assign bus.pause       = pause;
  assign bus.push_active = push_active;
  assign bus.issue_valid = issue_valid;
  assign bus.issue_warp  = issue_warp;
  assign bus.all_busy    = (bus.ready_warps == '0);

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_warp_scheduler : directed checks of push window and issue pick     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_warp_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_WARPS(4)) bus ();

  warp_scheduler #(.NUM_WARPS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_push(input string tag, input logic v, input logic [1:0] w,
                          input logic p, input logic a);
    check({tag, "_push_valid"}, 32'(bus.push_valid), 32'(v));
    check({tag, "_push_warp"}, 32'(bus.push_warp), 32'(w));
    check({tag, "_pause"}, 32'(bus.pause), 32'(p));
    check({tag, "_push_active"}, 32'(bus.push_active), 32'(a));
  endtask

  task automatic drive(input logic [3:0] rdy, input logic irdy, input logic pen,
                       input logic [1:0] ps, input logic [2:0] pc, input logic md);
    bus.ready_warps = rdy;
    bus.issue_ready = irdy;
    bus.push_en     = pen;
    bus.push_start  = ps;
    bus.push_count  = pc;
    bus.matmul_done = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #3;
    chk_push("rst", 1'b0, 2'd0, 1'b0, 1'b0);
    check("rst_all_busy", 32'(bus.all_busy), 1);
    check("rst_issue_valid", 32'(bus.issue_valid), 0);
    tick();
    reset = 1'b0;

    // Round-robin with every warp ready and every candidate accepted.
    for (int i = 0; i < 6; i++) begin
      drive(4'hF, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
      #1;
      check($sformatf("rr_issue_%0d", i), 32'(bus.issue_warp), 32'(rr_exp[i]));
      check("rr_push_valid", 32'(bus.push_valid), 0);
      check("rr_pause", 32'(bus.pause), 0);
      tick();
    end

    // Nothing ready: all_busy, no candidate, pointer (2) untouched.
    drive(4'h0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    check("busy_all_busy", 32'(bus.all_busy), 1);
    check("busy_issue_valid", 32'(bus.issue_valid), 0);
    check("busy_issue_warp", 32'(bus.issue_warp), 0);
    tick();

    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
      #1;
      check("stall_issue_warp", 32'(bus.issue_warp), 2);
      check("stall_issue_valid", 32'(bus.issue_valid), 1);
      check("stall_all_busy", 32'(bus.all_busy), 0);
      tick();
    end

    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    check("hold_ptr_issue_warp", 32'(bus.issue_warp), 2);
    drive(4'hF, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    tick();

    // Window start=3 count=3 with rr_ptr=3: issue must dodge warp 3.
    drive(4'hF, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0);
    #1;
    check("w1_idle_active", 32'(bus.push_active), 0);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w1_p0", 1'b1, 2'd3, 1'b0, 1'b1);
    check("w1_p0_issue", 32'(bus.issue_warp), 0);
    tick();
    #1;
    chk_push("w1_p1", 1'b1, 2'd0, 1'b0, 1'b1);
    check("w1_p1_issue", 32'(bus.issue_warp), 3);
    tick();
    #1;
    chk_push("w1_p2", 1'b1, 2'd1, 1'b0, 1'b1);
    check("w1_p2_issue", 32'(bus.issue_warp), 3);
    tick();
    drive(4'hF, 1'b0, 1'b1, 2'd2, 3'd1, 1'b0);
    #1;
    chk_push("w1_wait", 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    #1;
    chk_push("w1_wait_ignore_en", 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w1_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Same window, warp 0 not ready for two cycles.
    drive(4'hF, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w2_p0", 1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    drive(4'hE, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w2_pause0", 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    #1;
    chk_push("w2_pause1", 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w2_p1", 1'b1, 2'd0, 1'b0, 1'b1);
    tick();
    #1;
    chk_push("w2_p2", 1'b1, 2'd1, 1'b0, 1'b1);
    tick();
    #1;
    chk_push("w2_wait", 1'b0, 2'd0, 1'b0, 1'b1);
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w2_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Abort on the second push cycle, then restart with a new start.
    drive(4'hF, 1'b0, 1'b1, 2'd1, 3'd4, 1'b0);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w3_p0", 1'b1, 2'd1, 1'b0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    #1;
    chk_push("w3_abort", 1'b1, 2'd2, 1'b0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w3_idle", 1'b0, 2'd0, 1'b0, 1'b0);
    drive(4'hF, 1'b0, 1'b1, 2'd2, 3'd2, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w4_p0", 1'b1, 2'd2, 1'b0, 1'b1);
    tick();
    #1;
    chk_push("w4_p1", 1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    #1;
    chk_push("w4_wait", 1'b0, 2'd0, 1'b0, 1'b1);
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w4_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Reset mid-window at step 1 with rr_ptr=3.
    drive(4'hF, 1'b0, 1'b1, 2'd2, 3'd3, 1'b0);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w5_p0", 1'b1, 2'd2, 1'b0, 1'b1);
    tick();
    #1;
    chk_push("w5_p1", 1'b1, 2'd3, 1'b0, 1'b1);
    check("w5_p1_issue", 32'(bus.issue_warp), 0);
    #1;
    reset = 1'b1;
    #1;
    chk_push("w5_async_rst", 1'b0, 2'd0, 1'b0, 1'b0);
    check("w5_rst_issue_warp", 32'(bus.issue_warp), 0);
    check("w5_rst_issue_valid", 32'(bus.issue_valid), 1);
    #1;
    reset = 1'b0;

    // push_count=0 means a full NUM_WARPS window.
    drive(4'hF, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_push($sformatf("w6_p%0d", i), 1'b1, 2'(i + 1), 1'b0, 1'b1);
      tick();
    end
    #1;
    chk_push("w6_wait", 1'b0, 2'd0, 1'b0, 1'b1);
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    #1;
    chk_push("w6_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
Parametrised successor to the compute unit's warp selector. Arbitrates NUM_WARPS warps between two consumers:
- the systolic-array push path, which visits a programmable contiguous window of warps in order;
- the instruction issue path, which uses a round-robin pick with a valid/ready handshake.

Push reservations take priority over instruction issue, and the push path stalls (pause) when its next warp is not ready. The block sits between the warp-state table and the fetch/issue and push/pull units.

Parameters:
NUM_WARPS, 4, warp count; power of two, >= 2
WARP_W, $clog2(NUM_WARPS), warp index width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ready_warps  in  NUM_WARPS  per-warp ready flags from warp state table
push_en  in  1  one-cycle start pulse from control
push_start  in  WARP_W  first warp of push window, sampled with push_en
push_count  in  WARP_W+1  warps in push window, sampled with push_en; 0 means NUM_WARPS
matmul_done  in  1  push/pull unit reports matmul complete
push_valid  out  1  push_warp is granted to systolic path this cycle
push_warp  out  WARP_W  warp granted to push path (0 when !push_valid)
pause  out  1  systolic array must stall; needed warp not ready
push_active  out  1  FSM not IDLE
issue_valid  out  1  issue_warp is a valid instruction-issue candidate
issue_warp  out  WARP_W  round-robin selected warp (0 when !issue_valid)
issue_ready  in  1  issue stage accepts issue_warp
all_busy  out  1  ready_warps == 0; stall whole processor

Behaviour:
- Reset (async, any cycle including mid-push):
  - FSM -> IDLE; step, start_q, count_q, rr_ptr -> 0.
  - Combinational outputs follow from these: push_valid=0, push_warp=0, pause=0, push_active=0.
  - issue_valid/issue_warp follow ready_warps with rr_ptr=0.
- FSM states and transitions:
  - IDLE: on push_en, latch start_q=push_start and count_q (0 -> NUM_WARPS); step=0; go to PUSH. matmul_done is ignored in IDLE.
  - PUSH: cur = (start_q + step) mod NUM_WARPS, natural WARP_W wraparound.
    - If ready_warps[cur]: push_valid=1, push_warp=cur, pause=0. If step == count_q-1, go to WAIT_DONE; otherwise step+1.
    - If not ready: push_valid=0, pause=1, step held.
    - matmul_done in PUSH aborts to IDLE, and that cycle's grant is still presented.
  - WAIT_DONE: push_valid=0, pause=0; matmul_done -> IDLE.
  - push_en while not IDLE: ignored, no relatch.
  - push_en and matmul_done together in IDLE: push_en wins.
- Push outputs are combinational from registered state plus ready_warps: zero-latency grant.
- Instruction arbitration:
  - eligible = ready_warps & ~(push_valid ? onehot(push_warp) : 0).
  - Select first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_WARPS.
  - issue_valid = |eligible.
  - On issue_valid && issue_ready: rr_ptr <= issue_warp+1 mod NUM_WARPS. Otherwise rr_ptr holds.
  - The candidate may change while stalled (no stickiness).
  - A warp is never granted to both paths in one cycle.
- all_busy is combinational: ready_warps == 0, independent of FSM.
- Single warp window (count=1): one grant, then WAIT_DONE.

Decomposition:
- Shared package (warp_sched_pkg):
  - WARP_W helper function;
  - FSM state typedef {IDLE, PUSH, WAIT_DONE};
  - onehot-encode function.
- Natural sub-module: rr_arbiter, parametrised by N. Inputs: req, ptr, advance. Outputs: grant_valid, grant_idx, owns ptr register.

Test Plan:
- All ready, no push, issue_ready=1 for 6 cycles -> issue_warp 0,1,2,3,0,1; push_valid=0, pause=0.
- NUM_WARPS=4, push_start=3, push_count=3, all ready -> push_warp 3,0,1 on consecutive cycles, then WAIT_DONE; issue_warp never equals push_warp in the same cycle.
- Same window with ready_warps[0] low for 2 cycles -> after warp 3: pause=1, push_valid=0 for 2 cycles, then warp 0, then warp 1; step never skips.
- matmul_done asserted on second PUSH cycle -> FSM IDLE next cycle, push_active=0; a later push_en restarts from a newly latched push_start.
- ready_warps=0 -> all_busy=1, issue_valid=0; issue_ready=0 with candidate 2 held 3 cycles -> rr_ptr unchanged, issue_warp stays 2.
- Reset asserted mid-PUSH (step=1) -> outputs clear immediately without a clock edge; rr_ptr=0; push_count=0 after reset yields NUM_WARPS grants.
